// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, LFSR constants and helpers for the jump-game obstacle generator.
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_e;
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [1:0] MAX_LEVEL    = 2'd3;
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), reloaded with seed on reset.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= seed;
        else q <= lfsr_next(q);
endmodule

// File: rtl/barrier_gen.sv
// barrier_gen: game FSM, step timer, obstacle spawner/scroller and score keeper
// feeding the LED scan driver's barrier row.
module barrier_gen
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 5_000_000,
    parameter int unsigned MIN_GAP   = 3,
    parameter logic [7:0]  LFSR_SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
    output logic [7:0] barrier,
    output logic [7:0] score,
    output logic [1:0] level,
    output logic       running
);
    localparam int TW = $clog2(TICK_DIV);
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, top;
    logic [2:0]    gap_q, gap_d;
    logic [7:0]    barrier_q, barrier_d, score_q, score_d, lfsr;
    logic          step, spawn;

    lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .seed(LFSR_SEED), .q(lfsr));

    assign level   = (score_q[7:4] >= {2'b00, MAX_LEVEL}) ? MAX_LEVEL : score_q[5:4];
    assign top     = TW'((TICK_DIV >> level) - 1);
    assign barrier = barrier_q;
    assign score   = score_q;
    assign running = state_q == RUN;

    // level only changes right after a step, when tick_q is 0, so ">=" also covers a shrunken period
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        gap_d     = gap_q;
        barrier_d = barrier_q;
        score_d   = score_q;
        step      = 1'b0;
        spawn     = 1'b0;
        if (state_q == RUN) begin
            if (halt) state_d = OVER;
            else begin
                step   = tick_q >= top;
                tick_d = step ? '0 : tick_q + TW'(1);
                spawn  = step && gap_q >= 3'(MIN_GAP) && (lfsr & 8'h03) == 8'h00;
                if (step) begin
                    barrier_d = {spawn, barrier_q[7:1]};
                    gap_d     = spawn ? 3'd0 : (gap_q == 3'd7 ? gap_q : gap_q + 3'd1);
                    score_d   = (barrier_q[0] && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                end
            end
        end else if (start && !(state_q == OVER && halt)) begin
            state_d   = RUN;
            tick_d    = '0;
            gap_d     = '0;
            barrier_d = '0;
            score_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            gap_q     <= '0;
            barrier_q <= '0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            gap_q     <= gap_d;
            barrier_q <= barrier_d;
            score_q   <= score_d;
        end
endmodule

// File: tb/tb_barrier_gen.sv
// tb_barrier_gen: directed run of barrier_gen against a cycle model; step frames go through a scoreboard queue.
module tb_barrier_gen;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt = 1'b0;
    logic [7:0] barrier, score;
    logic [1:0] level;
    logic       running;
    int         checks = 0, errors = 0;
    int         m_state, m_tick, m_gap, m_bar, m_score, since_spawn;
    logic [7:0] m_lfsr;
    logic [15:0] sb[$];
    int         hb, hs;

    barrier_gen #(.TICK_DIV(8), .MIN_GAP(3), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .barrier(barrier), .score(score), .level(level), .running(running)
    );

    always #5 clk = ~clk;

    function automatic int m_level();
        return m_score >= 48 ? 3 : m_score / 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_tick = 0; m_gap = 0; m_bar = 0; m_score = 0;
        m_lfsr = 8'hA5; since_spawn = 0;
        sb.delete();
    endtask

    task automatic model_edge();
        int per;
        logic sp;
        logic [7:0] nl;
        nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (m_state == 1) begin
            if (halt) m_state = 2;
            else begin
                per = 8 >> m_level();
                if (m_tick == per - 1) begin
                    sp = m_gap >= 3 && m_lfsr[1:0] == 2'b00;
                    if (m_bar % 2 == 1 && m_score < 255) m_score++;
                    m_bar = (sp ? 128 : 0) + m_bar / 2;
                    m_gap = sp ? 0 : (m_gap < 7 ? m_gap + 1 : 7);
                    m_tick = 0;
                    sb.push_back({8'(m_bar), 8'(m_score)});
                end else m_tick++;
            end
        end else if (start && !(m_state == 2 && halt)) begin
            m_state = 1; m_tick = 0; m_gap = 0; m_bar = 0; m_score = 0; since_spawn = 0;
        end
        m_lfsr = nl;
    endtask

    task automatic cycle();
        logic [15:0] f;
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        chk("running", running, m_state == 1);
        chk("barrier", barrier, m_bar);
        chk("score", score, m_score);
        chk("level", level, m_level());
        chk("lfsr", dut.u_lfsr.q, m_lfsr);
        if (sb.size() > 0) begin
            f = sb.pop_front();
            chk("frame", {barrier, score}, f);
            since_spawn++;
            if (barrier[7]) begin
                chk("spawn_gap", since_spawn >= 4, 1);
                since_spawn = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_score(input int target);
        for (int i = 0; i < 20000 && m_score < target; i++) cycle();
        chk("score_reach", score, target);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_barrier", barrier, 0);
        chk("rst_score", score, 0);
        chk("rst_level", level, 0);
        chk("rst_running", running, 0);
        chk("rst_lfsr", dut.u_lfsr.q, 8'hA5);
        rst_n = 1'b1;
        run(100);
        chk("idle_barrier", barrier, 0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("start_running", running, 1);
        run(40);
        run_to_score(16);
        chk("level1", level, 1);
        run_to_score(48);
        chk("level3", level, 3);
        run_to_score(255);
        run(100);
        chk("score_sat", score, 8'hFF);
        halt = 1'b1; cycle();
        chk("halt_running", running, 0);
        hb = m_bar; hs = m_score;
        halt = 1'b0;
        run(50);
        chk("over_barrier", barrier, hb);
        chk("over_score", score, hs);
        start = 1'b1; halt = 1'b1; cycle();
        chk("stay_over", running, 0);
        halt = 1'b0; cycle();
        chk("restart_running", running, 1);
        chk("restart_barrier", barrier, 0);
        chk("restart_score", score, 0);
        chk("restart_level", level, 0);
        start = 1'b0;
        run(40);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_barrier", barrier, 0);
        chk("arst_score", score, 0);
        chk("arst_level", level, 0);
        chk("arst_running", running, 0);
        chk("arst_lfsr", dut.u_lfsr.q, 8'hA5);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        run(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
